// File: rtl/valu_gen.sv
// Small vector ALU: lane-wise add/sub with optional saturation, lane multiply,
// and a multiply-accumulate reduction into a persistent 32-bit accumulator.
module valu_gen #(
  parameter int VLEN = 128,
  parameter int NMUL = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [1:0]      sew,
  input  logic            sat,
  input  logic            acc_clr,
  input  logic [VLEN-1:0] vs1_data,
  input  logic [VLEN-1:0] vs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] result,
  output logic            err
);

  localparam int MAXL = VLEN / 8;
  localparam int LCW  = $clog2(MAXL) + 1;
  // Wide enough to hold the accumulator plus every product without overflow.
  localparam int PSW  = $clog2(MAXL) + 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic              mac_r, sat_r, acc_clr_r;
  logic [1:0]        sew_r;
  logic [VLEN-1:0]   vs1_r, vs2_r, result_r;
  logic [LCW-1:0]    lane_cnt_r, lanes_s;
  logic [PSW-1:0]    psum_r, grp_sum_s;
  logic signed [PSW-1:0] acc_sum_s;
  logic [31:0]       acc_r, acc_new_s;
  logic              err_r, accept_s, illegal_s, last_grp_s;
  logic [VLEN-1:0]   addsub_s;
  logic [31:0]       opa_s [NMUL];
  logic [31:0]       opb_s [NMUL];
  logic [31:0]       prod_s [NMUL];
  logic [NMUL-1:0]   slot_vld_s;

  function automatic logic [LCW-1:0] lane_count(input logic [1:0] w);
    case (w)
      2'b00:   lane_count = LCW'(VLEN / 8);
      2'b01:   lane_count = LCW'(VLEN / 16);
      2'b10:   lane_count = LCW'(VLEN / 32);
      default: lane_count = '0;
    endcase
  endfunction

  function automatic logic [31:0] get_lane(input logic [VLEN-1:0] v, input int idx,
                                           input logic [1:0] w);
    logic [7:0]  b8;
    logic [15:0] b16;
    case (w)
      2'b00: begin
        b8 = v[idx*8 +: 8];
        get_lane = {{24{b8[7]}}, b8};
      end
      2'b01: begin
        b16 = v[idx*16 +: 16];
        get_lane = {{16{b16[15]}}, b16};
      end
      2'b10:   get_lane = v[idx*32 +: 32];
      default: get_lane = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_as(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic st, input int w);
    logic signed [33:0] x, y, s, mx, mn;
    x  = {{2{a[31]}}, a};
    y  = {{2{b[31]}}, b};
    s  = sub ? (x - y) : (x + y);
    mx = (34'sd1 <<< (w - 1)) - 34'sd1;
    mn = -mx - 34'sd1;
    if (st && (s > mx)) begin
      s = mx;
    end else if (st && (s < mn)) begin
      s = mn;
    end else begin
      s = s;
    end
    lane_as = s[31:0];
  endfunction

  function automatic logic [VLEN-1:0] addsub_vec(input logic [VLEN-1:0] a,
                                                 input logic [VLEN-1:0] b,
                                                 input logic sub, input logic st,
                                                 input logic [1:0] w);
    logic [31:0] t;
    addsub_vec = '0;
    case (w)
      2'b00: for (int i = 0; i < VLEN / 8; i++) begin
        t = lane_as(get_lane(a, i, w), get_lane(b, i, w), sub, st, 8);
        addsub_vec[i*8 +: 8] = t[7:0];
      end
      2'b01: for (int i = 0; i < VLEN / 16; i++) begin
        t = lane_as(get_lane(a, i, w), get_lane(b, i, w), sub, st, 16);
        addsub_vec[i*16 +: 16] = t[15:0];
      end
      2'b10: for (int i = 0; i < VLEN / 32; i++) begin
        addsub_vec[i*32 +: 32] = lane_as(get_lane(a, i, w), get_lane(b, i, w), sub, st, 32);
      end
      default: addsub_vec = '0;
    endcase
  endfunction

  assign in_ready  = (state_r == IDLE) && rst_n;
  assign out_valid = (state_r == DONE);
  assign result    = result_r;
  assign err       = err_r;
  assign accept_s  = in_valid && in_ready;
  assign illegal_s = op[2] | (sew == 2'b11);
  assign addsub_s  = addsub_vec(vs1_data, vs2_data, op[0], sat, sew);

  // Multiplier slots for the current lane group and the reduction of their products.
  always_comb begin
    lanes_s    = lane_count(sew_r);
    grp_sum_s  = '0;
    slot_vld_s = '0;
    for (int j = 0; j < NMUL; j++) begin
      opa_s[j]  = 32'h0000_0000;
      opb_s[j]  = 32'h0000_0000;
      prod_s[j] = 32'h0000_0000;
      if ((int'(lane_cnt_r) + j) < int'(lanes_s)) begin
        slot_vld_s[j] = 1'b1;
        opa_s[j]      = get_lane(vs1_r, int'(lane_cnt_r) + j, sew_r);
        opb_s[j]      = get_lane(vs2_r, int'(lane_cnt_r) + j, sew_r);
        prod_s[j]     = opa_s[j] * opb_s[j];
        grp_sum_s     = grp_sum_s + {{(PSW-32){prod_s[j][31]}}, prod_s[j]};
      end else begin
        slot_vld_s[j] = 1'b0;
      end
    end
    last_grp_s = ((int'(lane_cnt_r) + NMUL) >= int'(lanes_s));
  end

  // Accumulator update with optional int32 clamping.
  always_comb begin
    acc_sum_s = $signed(psum_r) +
                (acc_clr_r ? $signed({PSW{1'b0}}) : $signed({{(PSW-32){acc_r[31]}}, acc_r}));
    if (sat_r && (acc_sum_s > $signed({{(PSW-32){1'b0}}, 32'h7FFF_FFFF}))) begin
      acc_new_s = 32'h7FFF_FFFF;
    end else if (sat_r && (acc_sum_s < $signed({{(PSW-32){1'b1}}, 32'h8000_0000}))) begin
      acc_new_s = 32'h8000_0000;
    end else begin
      acc_new_s = acc_sum_s[31:0];
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (illegal_s || !op[1]) ? DONE : MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        if (last_grp_s) begin
          state_s = mac_r ? SUM : DONE;
        end else begin
          state_s = MUL;
        end
      end
      SUM:  state_s = DONE;
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, lane-group processing and result/accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_r      <= 1'b0;
      sat_r      <= 1'b0;
      acc_clr_r  <= 1'b0;
      sew_r      <= 2'b00;
      vs1_r      <= '0;
      vs2_r      <= '0;
      lane_cnt_r <= '0;
      psum_r     <= '0;
      acc_r      <= 32'h0000_0000;
      result_r   <= '0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mac_r      <= op[0];
            sat_r      <= sat;
            acc_clr_r  <= acc_clr;
            sew_r      <= sew;
            vs1_r      <= vs1_data;
            vs2_r      <= vs2_data;
            lane_cnt_r <= '0;
            psum_r     <= '0;
            err_r      <= illegal_s;
            if (illegal_s || op[1]) begin
              result_r <= '0;
            end else begin
              result_r <= addsub_s;
            end
          end
        end
        MUL: begin
          lane_cnt_r <= lane_cnt_r + LCW'(NMUL);
          psum_r     <= psum_r + grp_sum_s;
          if (!mac_r) begin
            for (int j = 0; j < NMUL; j++) begin
              if (slot_vld_s[j]) begin
                case (sew_r)
                  2'b00:   result_r[(int'(lane_cnt_r) + j)*8 +: 8]   <= prod_s[j][7:0];
                  2'b01:   result_r[(int'(lane_cnt_r) + j)*16 +: 16] <= prod_s[j][15:0];
                  2'b10:   result_r[(int'(lane_cnt_r) + j)*32 +: 32] <= prod_s[j];
                  default: result_r <= result_r;
                endcase
              end
            end
          end
        end
        SUM: begin
          acc_r    <= acc_new_s;
          result_r <= {{(VLEN-32){1'b0}}, acc_new_s};
          err_r    <= 1'b0;
        end
        DONE:    result_r <= result_r;
        default: result_r <= result_r;
      endcase
    end
  end

endmodule

// File: tb/tb_valu_gen.sv
// Directed self-checking bench for valu_gen (VLEN=128, NMUL=4).
module tb_valu_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, sat, acc_clr, out_valid, out_ready, err;
  logic [2:0]   op;
  logic [1:0]   sew;
  logic [127:0] vs1_data, vs2_data, result, held;
  int           total = 0;
  int           bad = 0;

  valu_gen #(.VLEN(128), .NMUL(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sew(sew), .sat(sat), .acc_clr(acc_clr),
    .vs1_data(vs1_data), .vs2_data(vs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request: accept, scramble inputs, wait for out_valid, check, consume.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] s,
                        input logic st, input logic cl, input logic [127:0] a,
                        input logic [127:0] b, input int exp_lat,
                        input logic [127:0] exp_res, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 128'(in_ready), 128'd1);
    op = o; sew = s; sat = st; acc_clr = cl; vs1_data = a; vs2_data = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = ~o; sew = 2'b11; sat = ~st; acc_clr = ~cl; vs1_data = ~a; vs2_data = ~b;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_err"}, 128'(err), 128'(exp_err));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {126'd0, out_valid, in_ready}, 128'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; sew = 2'b00;
    sat = 1'b0; acc_clr = 1'b0; vs1_data = '0; vs2_data = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", {result[125:0], out_valid, err}, 128'd0);
    check("rst_rdy", 128'(in_ready), 128'd0);
    rst_n = 1'b1;
    #1 check("rel_rdy", 128'(in_ready), 128'd1);

    run_op("add8_wrap", 3'b000, 2'b00, 1'b0, 1'b0, {16{8'h7F}}, {16{8'h01}}, 1, {16{8'h80}}, 1'b0);
    run_op("add8_sat", 3'b000, 2'b00, 1'b1, 1'b0, {16{8'h7F}}, {16{8'h01}}, 1, {16{8'h7F}}, 1'b0);
    run_op("sub16_sat", 3'b001, 2'b01, 1'b1, 1'b0, {8{16'h8000}}, {8{16'h0001}}, 1, {8{16'h8000}}, 1'b0);
    run_op("sub16_wrap", 3'b001, 2'b01, 1'b0, 1'b0, {8{16'h8000}}, {8{16'h0001}}, 1, {8{16'h7FFF}}, 1'b0);
    run_op("add32_wrap", 3'b000, 2'b10, 1'b0, 1'b0, {4{32'hFFFF_FFFF}}, {4{32'h0000_0001}}, 1, 128'd0, 1'b0);
    run_op("mul16", 3'b010, 2'b01, 1'b1, 1'b0, {96'd0, 16'hFFFD, 16'h0100},
           {96'd0, 16'h0005, 16'h0100}, 3, {96'd0, 16'hFFF1, 16'h0000}, 1'b0);
    run_op("mul8", 3'b010, 2'b00, 1'b0, 1'b0, {16{8'hFF}}, {16{8'h05}}, 5, {16{8'hFB}}, 1'b0);
    run_op("mac8_clr", 3'b011, 2'b00, 1'b0, 1'b1, {16{8'h02}}, {16{8'h03}}, 6, 128'h60, 1'b0);
    run_op("mac8_acc", 3'b011, 2'b00, 1'b0, 1'b0, {16{8'h02}}, {16{8'h03}}, 6, 128'hC0, 1'b0);
    run_op("mac32_negsat", 3'b011, 2'b10, 1'b1, 1'b1, {4{32'h8000_0000}}, {4{32'h0000_0001}},
           3, 128'h8000_0000, 1'b0);
    run_op("mac32_pre", 3'b011, 2'b10, 1'b0, 1'b1, {96'd0, 32'h7FFF_FFF0}, {96'd0, 32'h1},
           3, 128'h7FFF_FFF0, 1'b0);
    run_op("mac32_sat", 3'b011, 2'b10, 1'b1, 1'b0, {96'd0, 32'h10}, {96'd0, 32'h10},
           3, 128'h7FFF_FFFF, 1'b0);
    run_op("mac32_wrapF0", 3'b011, 2'b10, 1'b0, 1'b0, {96'd0, 32'hF0}, {96'd0, 32'h1},
           3, 128'h8000_00EF, 1'b0);
    run_op("mac32_pre2", 3'b011, 2'b10, 1'b0, 1'b1, {96'd0, 32'h7FFF_FFF0}, {96'd0, 32'h1},
           3, 128'h7FFF_FFF0, 1'b0);
    run_op("mac32_wrap", 3'b011, 2'b10, 1'b0, 1'b0, {96'd0, 32'h10}, {96'd0, 32'h10},
           3, 128'h8000_00F0, 1'b0);

    // Backpressure: result held, new requests ignored while DONE.
    @(negedge clk);
    op = 3'b000; sew = 2'b10; sat = 1'b0; acc_clr = 1'b0;
    vs1_data = {4{32'h1}}; vs2_data = {4{32'h2}}; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_valid0", 128'(out_valid), 128'd1);
    check("bp_res0", result, {4{32'h3}});
    held = result;
    for (int i = 0; i < 5; i++) begin
      vs1_data = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_hold", {result, out_valid, in_ready}, {held, 1'b1, 1'b0});
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {126'd0, out_valid, in_ready}, 128'd1);
    repeat (3) @(posedge clk);
    #1 check("bp_noqueue", 128'(out_valid), 128'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op = 3'b010; sew = 2'b00; vs1_data = {16{8'h11}}; vs2_data = {16{8'h22}}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check("midrst_outs", {result[125:0], out_valid, err}, 128'd0);
    check("midrst_rdy", 128'(in_ready), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_rel", 128'(in_ready), 128'd1);
    repeat (6) @(posedge clk);
    #1 check("midrst_quiet", 128'(out_valid), 128'd0);
    run_op("mac_after_rst", 3'b011, 2'b00, 1'b0, 1'b0, {16{8'h01}}, {16{8'h01}}, 6, 128'h10, 1'b0);

    run_op("ill_sew", 3'b000, 2'b11, 1'b0, 1'b0, {16{8'h7F}}, {16{8'h01}}, 1, 128'd0, 1'b1);
    run_op("ill_op", 3'b111, 2'b00, 1'b0, 1'b0, {16{8'h02}}, {16{8'h03}}, 1, 128'd0, 1'b1);
    run_op("acc_kept", 3'b011, 2'b00, 1'b0, 1'b0, 128'd0, 128'd0, 6, 128'h10, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
